// File: rtl/cv32e40px_x_copro_adapter.sv
// CV-X-IF coprocessor endpoint: decodes custom-0 add/sub/xor, queues accepted
// instructions in order, executes committed ones on a fixed-latency ALU.
module cv32e40px_x_copro_adapter #(
    parameter int         DEPTH   = 4,
    parameter int         LATENCY = 2,
    parameter logic [6:0] OPCODE  = 7'h0B
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             x_issue_valid_i,
    output logic             x_issue_ready_o,
    input  logic [31:0]      x_issue_req_instr_i,
    input  logic [3:0]       x_issue_req_id_i,
    input  logic [1:0][31:0] x_issue_req_rs_i,
    input  logic [1:0]       x_issue_req_rs_valid_i,
    output logic             x_issue_resp_accept_o,
    output logic             x_issue_resp_writeback_o,
    output logic             x_issue_resp_dualwrite_o,
    output logic [2:0]       x_issue_resp_dualread_o,
    output logic             x_issue_resp_loadstore_o,
    input  logic             x_commit_valid_i,
    input  logic [3:0]       x_commit_id_i,
    input  logic             x_commit_kill_i,
    output logic             x_result_valid_o,
    input  logic             x_result_ready_i,
    output logic [3:0]       x_result_id_o,
    output logic [4:0]       x_result_rd_o,
    output logic [31:0]      x_result_data_o,
    output logic             x_result_we_o,
    output logic             busy_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
    typedef enum logic [2:0] {OP_ADD = 3'b000, OP_SUB = 3'b001, OP_XOR = 3'b100} alu_op_e;

    typedef struct packed {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        committed;
        logic        killed;
    } entry_t;

    entry_t           q [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [PW-1:0]    head_ptr;
    logic [PW-1:0]    tail_ptr;
    logic [PW:0]      count;
    state_e           state;
    logic [CW-1:0]    exec_cnt;

    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rd;
    logic [2:0]  dec_funct3;
    logic        legal;
    logic        full;
    logic        enq;
    logic        pop;
    logic        head_live;
    logic        kill_head;
    entry_t      head;
    logic [31:0] alu_result;
    logic        unused_instr_bits;

    assign dec_opcode        = x_issue_req_instr_i[6:0];
    assign dec_rd            = x_issue_req_instr_i[11:7];
    assign dec_funct3        = x_issue_req_instr_i[14:12];
    assign unused_instr_bits = ^x_issue_req_instr_i[31:15];

    assign legal = (dec_opcode == OPCODE) && (dec_funct3 inside {OP_ADD, OP_SUB, OP_XOR});
    assign full  = (count == (PW+1)'(DEPTH));

    // Illegal instructions still occupy the issue slot for one cycle, so they wait for space too.
    assign x_issue_ready_o          = ~full & (~legal | (&x_issue_req_rs_valid_i));
    assign x_issue_resp_accept_o    = legal;
    assign x_issue_resp_writeback_o = legal && (dec_rd != 5'd0);
    assign x_issue_resp_dualwrite_o = 1'b0;
    assign x_issue_resp_dualread_o  = 3'b000;
    assign x_issue_resp_loadstore_o = 1'b0;

    assign enq       = x_issue_valid_i & x_issue_ready_o & legal;
    assign head      = q[head_ptr];
    assign head_live = q_valid[head_ptr];
    assign kill_head = x_commit_valid_i & x_commit_kill_i & head_live & (x_commit_id_i == head.id);
    assign busy_o    = (count != '0) || (state != IDLE);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        alu_result = head.rs1 ^ head.rs2;
        case (head.funct3)
            OP_ADD:  alu_result = head.rs1 + head.rs2;
            OP_SUB:  alu_result = head.rs1 - head.rs2;
            default: ;
        endcase
    end

    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = head_live & head.killed;
            EXEC:    pop = kill_head | head.killed;
            RESP:    pop = x_result_ready_i;
            default: pop = 1'b0;
        endcase
    end

    // NOTE: the payload array is not reset; q_valid alone decides which slots are live.
    always_ff @(posedge clk_i) begin
        if (x_commit_valid_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_valid[PW'(i)] && (q[PW'(i)].id == x_commit_id_i)) begin
                    if (x_commit_kill_i) q[PW'(i)].killed    <= 1'b1;
                    else                 q[PW'(i)].committed <= 1'b1;
                end
            end
        end
        if (enq) begin
            q[tail_ptr] <= '{
                id:        x_issue_req_id_i,
                rd:        dec_rd,
                funct3:    dec_funct3,
                rs1:       x_issue_req_rs_i[0],
                rs2:       x_issue_req_rs_i[1],
                committed: x_commit_valid_i & ~x_commit_kill_i & (x_commit_id_i == x_issue_req_id_i),
                killed:    x_commit_valid_i &  x_commit_kill_i & (x_commit_id_i == x_issue_req_id_i)
            };
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_valid          <= '0;
            head_ptr         <= '0;
            tail_ptr         <= '0;
            count            <= '0;
            state            <= IDLE;
            exec_cnt         <= '0;
            x_result_valid_o <= 1'b0;
            x_result_id_o    <= '0;
            x_result_rd_o    <= '0;
            x_result_data_o  <= '0;
            x_result_we_o    <= 1'b0;
        end else begin
            if (pop) begin
                q_valid[head_ptr] <= 1'b0;
                head_ptr          <= head_ptr + 1'b1;
            end
            if (enq) begin
                q_valid[tail_ptr] <= 1'b1;
                tail_ptr          <= tail_ptr + 1'b1;
            end
            count <= count + (PW+1)'(enq) - (PW+1)'(pop);

            case (state)
                IDLE: begin
                    if (head_live && !head.killed && head.committed) begin
                        state    <= EXEC;
                        exec_cnt <= CW'(LATENCY - 1);
                    end
                end
                EXEC: begin
                    if (kill_head || head.killed) begin
                        state <= IDLE;
                    end else if (exec_cnt == '0) begin
                        state            <= RESP;
                        x_result_valid_o <= 1'b1;
                        x_result_id_o    <= head.id;
                        x_result_rd_o    <= head.rd;
                        x_result_data_o  <= alu_result;
                        x_result_we_o    <= (head.rd != 5'd0);
                    end else begin
                        exec_cnt <= exec_cnt - 1'b1;
                    end
                end
                RESP: begin
                    // A kill here is ignored: the result is already architectural.
                    if (x_result_ready_i) begin
                        state            <= IDLE;
                        x_result_valid_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cv32e40px_x_copro_adapter.sv
// Directed bench for cv32e40px_x_copro_adapter (DEPTH=4, LATENCY=2).
module tb_cv32e40px_x_copro_adapter;
    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             x_issue_valid_i;
    logic             x_issue_ready_o;
    logic [31:0]      x_issue_req_instr_i;
    logic [3:0]       x_issue_req_id_i;
    logic [1:0][31:0] x_issue_req_rs_i;
    logic [1:0]       x_issue_req_rs_valid_i;
    logic             x_issue_resp_accept_o;
    logic             x_issue_resp_writeback_o;
    logic             x_issue_resp_dualwrite_o;
    logic [2:0]       x_issue_resp_dualread_o;
    logic             x_issue_resp_loadstore_o;
    logic             x_commit_valid_i;
    logic [3:0]       x_commit_id_i;
    logic             x_commit_kill_i;
    logic             x_result_valid_o;
    logic             x_result_ready_i;
    logic [3:0]       x_result_id_o;
    logic [4:0]       x_result_rd_o;
    logic [31:0]      x_result_data_o;
    logic             x_result_we_o;
    logic             busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    cv32e40px_x_copro_adapter #(.DEPTH(4), .LATENCY(2), .OPCODE(7'h0B)) dut (
        .clk_i                    (clk_i),
        .rst_i                    (rst_i),
        .x_issue_valid_i          (x_issue_valid_i),
        .x_issue_ready_o          (x_issue_ready_o),
        .x_issue_req_instr_i      (x_issue_req_instr_i),
        .x_issue_req_id_i         (x_issue_req_id_i),
        .x_issue_req_rs_i         (x_issue_req_rs_i),
        .x_issue_req_rs_valid_i   (x_issue_req_rs_valid_i),
        .x_issue_resp_accept_o    (x_issue_resp_accept_o),
        .x_issue_resp_writeback_o (x_issue_resp_writeback_o),
        .x_issue_resp_dualwrite_o (x_issue_resp_dualwrite_o),
        .x_issue_resp_dualread_o  (x_issue_resp_dualread_o),
        .x_issue_resp_loadstore_o (x_issue_resp_loadstore_o),
        .x_commit_valid_i         (x_commit_valid_i),
        .x_commit_id_i            (x_commit_id_i),
        .x_commit_kill_i          (x_commit_kill_i),
        .x_result_valid_o         (x_result_valid_o),
        .x_result_ready_i         (x_result_ready_i),
        .x_result_id_o            (x_result_id_o),
        .x_result_rd_o            (x_result_rd_o),
        .x_result_data_o          (x_result_data_o),
        .x_result_we_o            (x_result_we_o),
        .busy_o                   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        mk = {17'h0, f3, rd, op};
    endfunction

    task automatic drive_issue(input logic [3:0] id, input logic [31:0] instr,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [1:0] rsv, input logic commit);
        x_issue_valid_i        = 1'b1;
        x_issue_req_id_i       = id;
        x_issue_req_instr_i    = instr;
        x_issue_req_rs_i       = {rs2, rs1};
        x_issue_req_rs_valid_i = rsv;
        x_commit_valid_i       = commit;
        x_commit_id_i          = id;
        x_commit_kill_i        = 1'b0;
        #1;
    endtask

    task automatic idle_inputs();
        x_issue_valid_i  = 1'b0;
        x_commit_valid_i = 1'b0;
        x_commit_kill_i  = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] id, input logic kill);
        x_commit_valid_i = 1'b1;
        x_commit_id_i    = id;
        x_commit_kill_i  = kill;
        step();
        x_commit_valid_i = 1'b0;
        x_commit_kill_i  = 1'b0;
    endtask

    // Counts edges until result_valid rises; a timeout shows up as a failed latency check.
    task automatic wait_result(output int n);
        n = 0;
        while (!x_result_valid_o && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic handshake();
        x_result_ready_i = 1'b1;
        step();
        x_result_ready_i = 1'b0;
    endtask

    int          lat;
    int          n_res;
    logic [3:0]  res_id [4];
    logic [31:0] res_data [4];

    initial begin
        rst_i = 1'b1;
        x_issue_valid_i = 1'b0;
        x_issue_req_instr_i = '0;
        x_issue_req_id_i = '0;
        x_issue_req_rs_i = '0;
        x_issue_req_rs_valid_i = '0;
        x_commit_valid_i = 1'b0;
        x_commit_id_i = '0;
        x_commit_kill_i = 1'b0;
        x_result_ready_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        check("reset_busy", busy_o, 0);
        check("reset_valid", x_result_valid_o, 0);

        // add id=3: 5+7 -> 12 into rd 10, committed in the issue cycle
        drive_issue(4'd3, mk(3'b000, 5'd10, 7'h0B), 32'd5, 32'd7, 2'b11, 1'b1);
        check("add_ready", x_issue_ready_o, 1);
        check("add_accept", x_issue_resp_accept_o, 1);
        check("add_writeback", x_issue_resp_writeback_o, 1);
        check("tied_zero", {x_issue_resp_dualwrite_o, x_issue_resp_dualread_o, x_issue_resp_loadstore_o}, 0);
        step();
        idle_inputs();
        wait_result(lat);
        check("add_latency", lat, 3);
        check("add_id", x_result_id_o, 3);
        check("add_rd", x_result_rd_o, 10);
        check("add_data", x_result_data_o, 12);
        check("add_we", x_result_we_o, 1);
        handshake();
        check("add_done_valid", x_result_valid_o, 0);
        check("add_done_busy", busy_o, 0);

        // Rejected instructions: bad funct3, then a non-custom opcode
        drive_issue(4'd5, mk(3'b010, 5'd1, 7'h0B), 32'd1, 32'd1, 2'b00, 1'b0);
        check("bad_f3_ready", x_issue_ready_o, 1);
        check("bad_f3_accept", x_issue_resp_accept_o, 0);
        step();
        drive_issue(4'd6, mk(3'b000, 5'd1, 7'h33), 32'd1, 32'd1, 2'b11, 1'b1);
        check("bad_op_ready", x_issue_ready_o, 1);
        check("bad_op_accept", x_issue_resp_accept_o, 0);
        step();
        idle_inputs();
        do_commit(4'd5, 1'b0);
        for (int i = 0; i < 6; i++) step();
        check("rejected_busy", busy_o, 0);
        check("rejected_valid", x_result_valid_o, 0);

        // sub 0-1 into rd 0: wraps, no register write
        drive_issue(4'd7, mk(3'b001, 5'd0, 7'h0B), 32'd0, 32'd1, 2'b11, 1'b1);
        check("sub_accept", x_issue_resp_accept_o, 1);
        check("sub_writeback", x_issue_resp_writeback_o, 0);
        step();
        idle_inputs();
        wait_result(lat);
        check("sub_latency", lat, 3);
        check("sub_id", x_result_id_o, 7);
        check("sub_data", x_result_data_o, 32'hFFFF_FFFF);
        check("sub_we", x_result_we_o, 0);
        handshake();

        // Fill the queue with four uncommitted instructions
        drive_issue(4'd1, mk(3'b000, 5'd1, 7'h0B), 32'd10, 32'd20, 2'b11, 1'b0);
        step();
        drive_issue(4'd2, mk(3'b000, 5'd2, 7'h0B), 32'd1, 32'd2, 2'b11, 1'b0);
        step();
        drive_issue(4'd3, mk(3'b100, 5'd3, 7'h0B), 32'h0000_F0F0, 32'h0000_0FF0, 2'b11, 1'b0);
        step();
        drive_issue(4'd4, mk(3'b001, 5'd4, 7'h0B), 32'd100, 32'd1, 2'b11, 1'b0);
        check("fill4_ready", x_issue_ready_o, 1);
        step();
        drive_issue(4'd5, mk(3'b000, 5'd5, 7'h0B), 32'd0, 32'd0, 2'b11, 1'b0);
        check("full_ready", x_issue_ready_o, 0);
        x_issue_req_instr_i = mk(3'b111, 5'd5, 7'h0B);
        #1;
        check("full_illegal_ready", x_issue_ready_o, 0);
        x_issue_req_instr_i = mk(3'b000, 5'd5, 7'h0B);
        idle_inputs();
        check("full_busy", busy_o, 1);
        do_commit(4'd1, 1'b0);
        do_commit(4'd2, 1'b1);
        do_commit(4'd3, 1'b0);
        do_commit(4'd4, 1'b0);
        wait_result(lat);
        check("q_first_valid", x_result_valid_o, 1);
        check("q_first_id", x_result_id_o, 1);
        check("q_first_data", x_result_data_o, 30);
        check("q_still_full", x_issue_ready_o, 0);
        handshake();
        check("q_ready_after_pop", x_issue_ready_o, 1);
        x_result_ready_i = 1'b1;
        n_res = 0;
        for (int i = 0; i < 30; i++) begin
            if (x_result_valid_o && n_res < 4) begin
                res_id[n_res]   = x_result_id_o;
                res_data[n_res] = x_result_data_o;
                n_res++;
            end
            step();
        end
        x_result_ready_i = 1'b0;
        check("q_rest_count", n_res, 2);
        check("q_second_id", res_id[0], 3);
        check("q_second_data", res_data[0], 32'h0000_FF00);
        check("q_third_id", res_id[1], 4);
        check("q_third_data", res_data[1], 99);
        check("q_drained_busy", busy_o, 0);

        // Back-pressure: result must hold while ready stays low
        drive_issue(4'd9, mk(3'b000, 5'd5, 7'h0B), 32'h1234_5678, 32'd1, 2'b11, 1'b1);
        step();
        drive_issue(4'd10, mk(3'b100, 5'd6, 7'h0B), 32'hFFFF_0000, 32'h00FF_FF00, 2'b11, 1'b1);
        step();
        idle_inputs();
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", x_result_valid_o, 1);
            check("bp_id", x_result_id_o, 9);
            check("bp_data", x_result_data_o, 32'h1234_5679);
        end
        handshake();
        check("bp_drop", x_result_valid_o, 0);
        wait_result(lat);
        check("bp_next_latency", lat, 3);
        check("bp_next_id", x_result_id_o, 10);
        check("bp_next_data", x_result_data_o, 32'hFF00_FF00);
        handshake();

        // Reset while executing with two entries queued
        drive_issue(4'd11, mk(3'b000, 5'd8, 7'h0B), 32'd1, 32'd1, 2'b11, 1'b1);
        step();
        drive_issue(4'd12, mk(3'b000, 5'd9, 7'h0B), 32'd2, 32'd2, 2'b11, 1'b0);
        step();
        idle_inputs();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rst_busy", busy_o, 0);
        check("rst_valid", x_result_valid_o, 0);
        for (int i = 0; i < 5; i++) step();
        check("rst_no_result", x_result_valid_o, 0);
        drive_issue(4'd13, mk(3'b000, 5'd7, 7'h0B), 32'd2, 32'd3, 2'b11, 1'b1);
        check("post_rst_accept", x_issue_resp_accept_o, 1);
        step();
        idle_inputs();
        wait_result(lat);
        check("post_rst_latency", lat, 3);
        check("post_rst_id", x_result_id_o, 13);
        check("post_rst_data", x_result_data_o, 5);
        handshake();
        check("post_rst_busy", busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cv32e40px_x_copro_adapter.md
Name: cv32e40px_x_copro_adapter

Overview:
- Coprocessor-side responder for the core's CV-X-IF issue, commit and result channels.
- Decodes offloaded custom-0 instructions and accepts or rejects each one.
- Buffers accepted instructions in an in-order queue until they are committed or killed.
- Executes each committed instruction on a fixed-latency ALU and returns the result over the result handshake.
- Serves as the reference coprocessor endpoint for core-side dispatcher bring-up and verification.

Parameters:
DEPTH, 4, number of queue entries; power of two, 2..16
LATENCY, 2, execute cycles per instruction; must be >= 1
OPCODE, 7'h0B, major opcode this adapter accepts

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous and active-high
x_issue_valid_i  in  1  issue request valid
x_issue_ready_o  out  1  issue request ready
x_issue_req_instr_i  in  32  offloaded instruction word
x_issue_req_id_i  in  4  instruction id
x_issue_req_rs_i  in  2x32  source operands rs1 and rs2
x_issue_req_rs_valid_i  in  2  per-operand valid
x_issue_resp_accept_o  out  1  instruction accepted
x_issue_resp_writeback_o  out  1  instruction will write rd
x_issue_resp_dualwrite_o  out  1  tied 0
x_issue_resp_dualread_o  out  3  tied 0
x_issue_resp_loadstore_o  out  1  tied 0
x_commit_valid_i  in  1  commit valid
x_commit_id_i  in  4  id being committed or killed
x_commit_kill_i  in  1  1 = kill, 0 = commit
x_result_valid_o  out  1  result valid
x_result_ready_i  in  1  result ready
x_result_id_o  out  4  id of the result
x_result_rd_o  out  5  destination register
x_result_data_o  out  32  result data
x_result_we_o  out  1  register-file write enable
busy_o  out  1  queue non-empty or FSM not IDLE

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge):
  - Queue empties, pointers and count go to 0, FSM goes to IDLE.
  - x_result_valid_o=0, busy_o=0.
  - Reset mid-execute or mid-response drops everything with no result emitted.
- Decode (combinational on instr):
  - legal = opcode==OPCODE and funct3 in {000 add, 001 sub, 100 xor}.
  - accept_o = legal.
  - writeback_o = legal and rd!=0.
  - Response outputs are meaningful only while valid_i and ready_o are both high.
- Issue ready:
  - ready_o = ~full & (~legal | (rs_valid[0] & rs_valid[1])).
  - Illegal instructions still need a free slot and are answered accept=0 in one cycle; they are never enqueued.
  - No bypass: a pop in the same cycle does not raise ready while full.
- Enqueue on valid & ready & legal. Each entry stores id, rd, funct3, rs1, rs2, committed=0, killed=0.
- Commit (x_commit_valid_i):
  - Matched against every valid entry and against the instruction enqueuing in the same cycle.
  - Kill sets killed; otherwise it sets committed.
  - A commit for an unknown id or a rejected instruction is ignored.
  - Ids are unique among live entries.
- FSM, strictly in order, from the queue head:
  - IDLE: head killed -> pop, stay IDLE (1 cycle, no result). Head committed -> EXEC with counter=LATENCY-1. Otherwise stay.
  - EXEC: compute result, decrement counter; at 0 register the result and go to RESP.
  - RESP: x_result_valid_o=1 with id, rd, data, and we = rd!=0 held stable until x_result_ready_i. On handshake pop the head and go to IDLE.
  - Issue-to-result with immediate commit and ready=1 takes LATENCY+2 cycles.
- Arithmetic: 32-bit wrap-around; sub = rs1 - rs2 mod 2^32.
- A kill arriving for the head while in EXEC aborts: pop, go to IDLE, no result. A kill in RESP is ignored because the result is already architectural.
- Count ranges 0..DEPTH. full = (count==DEPTH). Pointers wrap modulo DEPTH.

Test Plan:
- Reset, then issue add (id=3, rs1=5, rs2=7, rd=10) with same-cycle commit: accept=1 and writeback=1; result id=3, rd=10, data=12, we=1 appears 4 cycles after issue (LATENCY=2).
- Issue funct3=010, or issue a non-custom opcode: ready=1, accept=0 in the same cycle; no result is ever produced and busy_o stays 0.
- Issue sub with rs1=0, rs2=1, rd=0: data=32'hFFFFFFFF, we=0, writeback_o=0.
- Issue 4 instructions without commit: 5th issue sees ready=0. Commit ids in order with kill on the 2nd: exactly 3 results emerge in issue order; ready returns 1 after the first pop.
- Hold result_ready=0 for 5 cycles in RESP: valid and data stay stable; the next head does not start until the handshake.
- Assert rst_i during EXEC with 2 entries queued: the next cycle shows busy_o=0 and result_valid=0; a fresh issue after reset completes normally.
